// File: rtl/cpx_spc_rpt_buf.sv
// cpx_spc_rpt_buf
// CPX-to-SPARC repeater: STAGES flops of pipelined transport from the crossbar,
// then a DEPTH-entry credit-managed elastic buffer that the core drains at its
// own pace. Every accepted dequeue returns a one-cycle credit pulse upstream.
// Dropped packets (overflow) and pops of an empty buffer (underflow) raise
// sticky error flags that hold until err_clr.
module cpx_spc_rpt_buf #(
   parameter int WIDTH  = 145,
   parameter int STAGES = 1,
   parameter int DEPTH  = 4,
   parameter int CNTW   = $clog2(DEPTH + 1)
) (
   input  logic             rclk,
   input  logic             arst_l,
   input  logic [WIDTH-1:0] cpx_spc_data_cx2,
   input  logic             cpx_spc_data_rdy_cx2,
   input  logic             spc_cpx_deq,
   input  logic             err_clr,
   output logic [WIDTH-1:0] cpx_spc_data_out,
   output logic             cpx_spc_data_vld_out,
   output logic [4:0]       cpx_spc_data_out_b144to140,
   output logic             spc_cpx_credit_ret,
   output logic [CNTW-1:0]  buf_count,
   output logic             ovf_err,
   output logic             udf_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // ------------------------------------------------------------------
   // Repeater stages
   // ------------------------------------------------------------------
   logic [STAGES-1:0] stg_vld_q, stg_vld_d;
   logic [WIDTH-1:0]  stg_data_q [STAGES];
   logic [WIDTH-1:0]  stg_data_d [STAGES];

   // Link k feeds stage k; link 0 is the cx2 input.
   logic [STAGES:0]   chain_vld;
   logic [WIDTH-1:0]  chain_data [STAGES+1];

   // Build the source chain and next-state for each repeater stage.
   always_comb begin
      // NOTE: every variable written here gets a value on every path first,
      // so no latch can be inferred.
      chain_vld     = '0;
      chain_vld[0]  = cpx_spc_data_rdy_cx2;
      chain_data[0] = cpx_spc_data_cx2;
      for (int k = 0; k < STAGES; k++) begin
         chain_vld[k+1]  = stg_vld_q[k];
         chain_data[k+1] = stg_data_q[k];
      end
      for (int k = 0; k < STAGES; k++) begin
         stg_vld_d[k]  = chain_vld[k];
         // Data only toggles when something real is moving through.
         stg_data_d[k] = chain_vld[k] ? chain_data[k] : stg_data_q[k];
      end
   end

   // Stage valid bits: cleared by reset so a flush drops in-flight packets.
   always_ff @(posedge rclk or negedge arst_l) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!arst_l) stg_vld_q <= '0;
      else         stg_vld_q <= stg_vld_d;
   end

   // Stage data registers: payload only, qualified by the valid bits.
   always_ff @(posedge rclk) begin
      // NOTE: payload registers and buffer storage are deliberately not reset;
      // they are only observed when a matching valid bit is set.
      for (int k = 0; k < STAGES; k++) stg_data_q[k] <= stg_data_d[k];
   end

   // ------------------------------------------------------------------
   // Elastic buffer
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             credit_q, credit_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   logic             enq_req;
   logic [WIDTH-1:0] enq_data;
   logic             buf_empty;
   logic             buf_full;
   logic             deq_ok;
   logic             enq_ok;
   logic             ovf_evt;
   logic             udf_evt;

   // Accept/drop decisions and next-state for pointers, count, flags, storage.
   always_comb begin
      enq_req   = stg_vld_q[STAGES-1];
      enq_data  = stg_data_q[STAGES-1];
      buf_empty = (cnt_q == '0);
      buf_full  = (cnt_q == CNTW'(DEPTH));

      // A pop of an empty buffer is ignored; a push into a full buffer only
      // fits if the head leaves in the same cycle.
      deq_ok  = spc_cpx_deq & ~buf_empty;
      udf_evt = spc_cpx_deq &  buf_empty;
      enq_ok  = enq_req & (~buf_full | deq_ok);
      ovf_evt = enq_req &   buf_full & ~deq_ok;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      if (enq_ok) begin
         mem_d[wr_ptr_q] = enq_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (deq_ok) rd_ptr_d = rd_ptr_q + AW'(1);

      case ({enq_ok, deq_ok})
         2'b10:   cnt_d = cnt_q + CNTW'(1);
         2'b01:   cnt_d = cnt_q - CNTW'(1);
         default: cnt_d = cnt_q;
      endcase

      credit_d = deq_ok;
      // A new error event wins over a coincident clear.
      ovf_d    = ovf_evt | (ovf_q & ~err_clr);
      udf_d    = udf_evt | (udf_q & ~err_clr);
   end

   // Buffer control state: pointers, occupancy, credit pulse, sticky errors.
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         credit_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         credit_q <= credit_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Buffer storage array.
   always_ff @(posedge rclk) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign cpx_spc_data_out           = mem_q[rd_ptr_q];
   assign cpx_spc_data_vld_out       = (cnt_q != '0);
   assign cpx_spc_data_out_b144to140 = cpx_spc_data_out[WIDTH-1 -: 5];
   assign spc_cpx_credit_ret         = credit_q;
   assign buf_count                  = cnt_q;
   assign ovf_err                    = ovf_q;
   assign udf_err                    = udf_q;

endmodule

// File: tb/tb_cpx_spc_rpt_buf.sv
// tb_cpx_spc_rpt_buf
// Drives two instances (STAGES=1 and STAGES=3, DEPTH=4) with identical
// stimulus and compares every output, every cycle, against a queue-style
// packet model: a delay line per instance feeding an ordered list of buffered
// packets whose head is element 0.
module tb_cpx_spc_rpt_buf;

   localparam int W    = 145;
   localparam int D    = 4;
   localparam int CW   = $clog2(D + 1);
   localparam int S0   = 1;
   localparam int S1   = 3;

   logic          rclk;
   logic          arst_l;
   logic [W-1:0]  din;
   logic          rdy;
   logic          deq;
   logic          clr;

   logic [W-1:0]  o_data [2];
   logic          o_vld  [2];
   logic [4:0]    o_b5   [2];
   logic          o_cred [2];
   logic [CW-1:0] o_cnt  [2];
   logic          o_ovf  [2];
   logic          o_udf  [2];

   cpx_spc_rpt_buf #(.WIDTH(W), .STAGES(S0), .DEPTH(D)) dut1 (
      .rclk                       (rclk),
      .arst_l                     (arst_l),
      .cpx_spc_data_cx2           (din),
      .cpx_spc_data_rdy_cx2       (rdy),
      .spc_cpx_deq                (deq),
      .err_clr                    (clr),
      .cpx_spc_data_out           (o_data[0]),
      .cpx_spc_data_vld_out       (o_vld[0]),
      .cpx_spc_data_out_b144to140 (o_b5[0]),
      .spc_cpx_credit_ret         (o_cred[0]),
      .buf_count                  (o_cnt[0]),
      .ovf_err                    (o_ovf[0]),
      .udf_err                    (o_udf[0])
   );

   cpx_spc_rpt_buf #(.WIDTH(W), .STAGES(S1), .DEPTH(D)) dut3 (
      .rclk                       (rclk),
      .arst_l                     (arst_l),
      .cpx_spc_data_cx2           (din),
      .cpx_spc_data_rdy_cx2       (rdy),
      .spc_cpx_deq                (deq),
      .err_clr                    (clr),
      .cpx_spc_data_out           (o_data[1]),
      .cpx_spc_data_vld_out       (o_vld[1]),
      .cpx_spc_data_out_b144to140 (o_b5[1]),
      .spc_cpx_credit_ret         (o_cred[1]),
      .buf_count                  (o_cnt[1]),
      .ovf_err                    (o_ovf[1]),
      .udf_err                    (o_udf[1])
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   // ---------------- reference model ----------------
   logic          pv [2][4];
   logic [W-1:0]  pd [2][4];
   logic [W-1:0]  mb [2][D];
   int            mc [2];
   logic          mcred [2];
   logic          movf  [2];
   logic          mudf  [2];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int cred_n [2];
   int max_cnt3;
   int first_vld3;
   int t0;

   function automatic int stg_of(input int m);
      return (m == 0) ? S0 : S1;
   endfunction

   function automatic logic [W-1:0] rand_pkt();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[W-1:0];
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 4; k++) pv[m][k] = 1'b0;
         mc[m]    = 0;
         mcred[m] = 1'b0;
         movf[m]  = 1'b0;
         mudf[m]  = 1'b0;
      end
   endtask

   // One clock edge of packet-level behaviour for both instances.
   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         int           s;
         logic         deq_ok, lv, ovf, udf;
         logic [W-1:0] ld;
         s      = stg_of(m);
         lv     = pv[m][s-1];
         ld     = pd[m][s-1];
         deq_ok = deq && (mc[m] > 0);
         udf    = deq && (mc[m] == 0);
         ovf    = lv && (mc[m] == D) && !deq_ok;
         if (deq_ok) begin
            for (int i = 0; i < D - 1; i++) mb[m][i] = mb[m][i+1];
            mc[m]--;
         end
         if (lv && !ovf) begin
            mb[m][mc[m]] = ld;
            mc[m]++;
         end
         mcred[m] = deq_ok;
         movf[m]  = ovf || (movf[m] && !clr);
         mudf[m]  = udf || (mudf[m] && !clr);
         for (int k = s - 1; k > 0; k--) begin
            if (pv[m][k-1]) pd[m][k] = pd[m][k-1];
            pv[m][k] = pv[m][k-1];
         end
         pv[m][0] = rdy;
         if (rdy) pd[m][0] = din;
      end
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         logic [W-1:0] h;
         h = mb[m][0];
         check($sformatf("d%0d_vld", m), W'(o_vld[m]), W'(mc[m] != 0));
         if (mc[m] != 0) begin
            check($sformatf("d%0d_data", m), o_data[m], h);
            check($sformatf("d%0d_b5", m), W'(o_b5[m]), W'(h[W-1 -: 5]));
         end
         check($sformatf("d%0d_cnt", m),  W'(o_cnt[m]),  W'(mc[m]));
         check($sformatf("d%0d_cred", m), W'(o_cred[m]), W'(mcred[m]));
         check($sformatf("d%0d_ovf", m),  W'(o_ovf[m]),  W'(movf[m]));
         check($sformatf("d%0d_udf", m),  W'(o_udf[m]),  W'(mudf[m]));
      end
   endtask

   // Advance one cycle: edge, model update, then sample on the falling edge.
   task automatic tick();
      @(posedge rclk);
      model_step();
      @(negedge rclk);
      cyc++;
      check_all();
      for (int m = 0; m < 2; m++) cred_n[m] += int'(o_cred[m]);
      if (int'(o_cnt[1]) > max_cnt3) max_cnt3 = int'(o_cnt[1]);
      if (o_vld[1] && first_vld3 < 0) first_vld3 = cyc - t0;
   endtask

   // Assert reset between edges, check the immediate effect, release later.
   task automatic do_reset();
      #2 arst_l = 1'b0;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         check($sformatf("rst_d%0d_vld", m),  W'(o_vld[m]),  '0);
         check($sformatf("rst_d%0d_cnt", m),  W'(o_cnt[m]),  '0);
         check($sformatf("rst_d%0d_cred", m), W'(o_cred[m]), '0);
         check($sformatf("rst_d%0d_ovf", m),  W'(o_ovf[m]),  '0);
         check($sformatf("rst_d%0d_udf", m),  W'(o_udf[m]),  '0);
      end
      @(negedge rclk);
      arst_l = 1'b1;
   endtask

   initial begin
      logic [W-1:0] pkt_a;
      arst_l = 1'b0;
      din = '0; rdy = 1'b0; deq = 1'b0; clr = 1'b0;
      cred_n[0] = 0; cred_n[1] = 0;
      max_cnt3 = 0; first_vld3 = -1; t0 = 0;
      model_reset();
      #3 check_all();
      @(negedge rclk);
      arst_l = 1'b1;
      tick();

      // 1. single packet latency
      din = W'(145'h1_2345); rdy = 1'b1;
      tick();
      rdy = 1'b0;
      tick();
      check("lat1_vld", W'(o_vld[0]), W'(1));
      check("lat1_data", o_data[0], W'(145'h1_2345));
      check("lat1_cnt", W'(o_cnt[0]), W'(1));
      check("lat1_b5", W'(o_b5[0]), W'(5'h00));
      deq = 1'b1;
      repeat (3) tick();
      deq = 1'b0;
      tick();
      clr = 1'b1; tick(); clr = 1'b0;

      // 2. back-to-back streaming with the core popping every cycle
      cred_n[0] = 0; cred_n[1] = 0; max_cnt3 = 0; first_vld3 = -1;
      t0 = cyc; deq = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = W'(i); rdy = 1'b1;
         tick();
      end
      rdy = 1'b0;
      repeat (6) tick();
      check("stream_first3", W'(first_vld3), W'(4));
      check("stream_cred1", W'(cred_n[0]), W'(8));
      check("stream_cred3", W'(cred_n[1]), W'(8));
      check("stream_max3", W'(max_cnt3), W'(1));
      deq = 1'b0; clr = 1'b1; tick(); clr = 1'b0;

      // 3. fill then overflow
      for (int i = 1; i <= 5; i++) begin
         din = W'(i); rdy = 1'b1;
         tick();
      end
      rdy = 1'b0;
      repeat (4) tick();
      for (int m = 0; m < 2; m++) begin
         check($sformatf("ovf_d%0d_cnt", m), W'(o_cnt[m]), W'(4));
         check($sformatf("ovf_d%0d_flag", m), W'(o_ovf[m]), W'(1));
         check($sformatf("ovf_d%0d_head", m), o_data[m], W'(1));
      end
      cred_n[0] = 0; cred_n[1] = 0;
      deq = 1'b1;
      repeat (4) tick();
      deq = 1'b0;
      tick();
      check("drain_cred1", W'(cred_n[0]), W'(4));
      check("drain_cred3", W'(cred_n[1]), W'(4));
      clr = 1'b1; tick(); clr = 1'b0;
      check("ovf_clr1", W'(o_ovf[0]), W'(0));

      // 4. full buffer, enqueue and dequeue in the same cycle
      for (int i = 11; i <= 14; i++) begin
         din = W'(i); rdy = 1'b1;
         tick();
      end
      rdy = 1'b0;
      repeat (4) tick();
      pkt_a = W'(145'h1f_0000_00aa);
      din = pkt_a; rdy = 1'b1;
      tick();
      rdy = 1'b0; deq = 1'b1;
      tick();
      deq = 1'b0;
      check("full_sim_cnt", W'(o_cnt[0]), W'(4));
      check("full_sim_cred", W'(o_cred[0]), W'(1));
      check("full_sim_ovf", W'(o_ovf[0]), W'(0));
      check("full_sim_head", o_data[0], W'(12));
      repeat (3) tick();
      deq = 1'b1;
      repeat (3) tick();
      check("full_sim_tail", o_data[0], pkt_a);
      tick();

      // 5. underflow, and clear colliding with a new underflow
      tick();
      check("udf_set", W'(o_udf[0]), W'(1));
      check("udf_nocred", W'(o_cred[0]), W'(0));
      clr = 1'b1;
      tick();
      check("udf_setwins", W'(o_udf[0]), W'(1));
      deq = 1'b0;
      tick();
      clr = 1'b0;
      check("udf_clr", W'(o_udf[0]), W'(0));

      // 6. async reset mid-stream
      for (int i = 21; i <= 25; i++) begin
         din = W'(i); rdy = 1'b1;
         tick();
      end
      rdy = 1'b0;
      do_reset();
      din = W'(145'h77); rdy = 1'b1;
      tick();
      rdy = 1'b0;
      tick();
      check("post_rst_d1", o_data[0], W'(145'h77));
      check("post_rst_d1cnt", W'(o_cnt[0]), W'(1));
      repeat (2) tick();
      check("post_rst_d3", o_data[1], W'(145'h77));
      check("post_rst_d3cnt", W'(o_cnt[1]), W'(1));
      deq = 1'b1; tick(); deq = 1'b0;

      // 7. random traffic with varying pop pressure, rare clears and resets
      for (int ph = 0; ph < 6; ph++) begin
         int unsigned deq_pct;
         deq_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 95);
         for (int i = 0; i < 500; i++) begin
            rdy = ($urandom_range(0, 99) < 60);
            din = rand_pkt();
            deq = ($urandom_range(0, 99) < deq_pct);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick();
         end
      end
      rdy = 1'b0; deq = 1'b0; clr = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
